// File: rtl/murphi_rule_scheduler.sv
// Rule scheduler for a Murphi-generated system block.
// Each step samples the rule guards in SELECT, grants one enabled rule
// (round-robin or LFSR-seeded scan), and pulses its one-hot enable for a
// single FIRE cycle. It counts fired steps, stops at a programmable limit,
// and flags deadlock after DEADLOCK_LIMIT consecutive empty SELECT cycles.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   io_start       start a run (honoured in IDLE, DONE, DEADLOCK)
//   io_mode        0 = round-robin, 1 = LFSR; latched on start
//   io_hold        pause selection while high (SELECT only)
//   io_max_steps   step limit, 0 = unlimited; latched on start
//   io_guards      per-rule guard truth
//   io_en_a        registered one-hot rule enable
//   io_busy        high in SELECT or FIRE
//   io_done        high in DONE
//   io_deadlock    high in DEADLOCK
//   io_step_count  rules fired since the last start
module murphi_rule_scheduler #(
  parameter int unsigned NUM_RULES      = 4,
  parameter int unsigned DEADLOCK_LIMIT = 8,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_mode,
  input  logic                 io_hold,
  input  logic [15:0]          io_max_steps,
  input  logic [NUM_RULES-1:0] io_guards,
  output logic [NUM_RULES-1:0] io_en_a,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_deadlock,
  output logic [15:0]          io_step_count
);

  localparam int unsigned IW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
  localparam int unsigned CW = 16;
  localparam int unsigned LW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_FIRE,
    S_DONE,
    S_DEADLOCK
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_RULES-1:0] en_q, en_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        max_q, max_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [LW-1:0]        idle_q, idle_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dead_q, dead_d;

  logic [IW-1:0]        scan_start;
  logic [IW-1:0]        scan_idx;
  logic [IW-1:0]        pick;
  logic                 found;
  logic [7:0]           lfsr_next;
  logic [CW-1:0]        cnt_inc;
  logic [LW-1:0]        idle_inc;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, shifting left into bit 0
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + CW'(1);
  assign idle_inc  = idle_q + LW'(1);

  // First set guard scanning upward from the start index, wrapping modulo NUM_RULES
  always_comb begin
    scan_start = mode_q ? lfsr_q[IW-1:0] : ptr_q;
    scan_idx   = '0;
    pick       = '0;
    found      = 1'b0;
    for (int i = 0; i < int'(NUM_RULES); i++) begin
      scan_idx = scan_start + IW'(i);
      if (!found && io_guards[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    en_d    = '0;
    cnt_d   = cnt_q;
    max_d   = max_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    lfsr_d  = lfsr_q;
    idle_d  = idle_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE, S_DONE, S_DEADLOCK: begin
        if (io_start) begin
          cnt_d   = '0;
          idle_d  = '0;
          ptr_d   = '0;
          lfsr_d  = LFSR_SEED;
          mode_d  = io_mode;
          max_d   = io_max_steps;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (!io_hold) begin
          lfsr_d = lfsr_next;
          if (found) begin
            en_d    = NUM_RULES'(1) << pick;
            grant_d = pick;
            idle_d  = '0;
            state_d = S_FIRE;
          end else begin
            idle_d = idle_inc;
            if (idle_inc == LW'(DEADLOCK_LIMIT)) state_d = S_DEADLOCK;
          end
        end
      end
      S_FIRE: begin
        cnt_d = cnt_inc;
        ptr_d = grant_q + IW'(1);
        if ((max_q != '0) && (cnt_inc == max_q)) state_d = S_DONE;
        else                                     state_d = S_SELECT;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SELECT) || (state_d == S_FIRE);
    done_d = (state_d == S_DONE);
    dead_d = (state_d == S_DEADLOCK);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      lfsr_q  <= LFSR_SEED;
      idle_q  <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      lfsr_q  <= lfsr_d;
      idle_q  <= idle_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dead_q  <= dead_d;
    end
  end

  assign io_en_a       = en_q;
  assign io_busy       = busy_q;
  assign io_done       = done_q;
  assign io_deadlock   = dead_q;
  assign io_step_count = cnt_q;

endmodule

// File: tb/tb_murphi_rule_scheduler.sv
// Self-checking bench for murphi_rule_scheduler: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_murphi_rule_scheduler;

  localparam int N     = 4;
  localparam int LIMIT = 8;

  logic         clock;
  logic         reset;
  logic         io_start;
  logic         io_mode;
  logic         io_hold;
  logic [15:0]  io_max_steps;
  logic [N-1:0] io_guards;
  logic [N-1:0] io_en_a;
  logic         io_busy;
  logic         io_done;
  logic         io_deadlock;
  logic [15:0]  io_step_count;

  int checks;
  int failures;

  murphi_rule_scheduler #(
    .NUM_RULES     (N),
    .DEADLOCK_LIMIT(LIMIT),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_start     (io_start),
    .io_mode      (io_mode),
    .io_hold      (io_hold),
    .io_max_steps (io_max_steps),
    .io_guards    (io_guards),
    .io_en_a      (io_en_a),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_deadlock  (io_deadlock),
    .io_step_count(io_step_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; sample and drive 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference LFSR: taps 8,6,5,4 -> bits 7,5,4,3, shift left into bit 0
  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  // First enabled rule scanning start, start+1, ... modulo N; -1 if none
  function automatic int pick_rule(input int start, input int guards);
    for (int k = 0; k < N; k++)
      if ((guards >> ((start + k) % N)) & 1) return (start + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    io_start = 0; io_mode = 0; io_hold = 0; io_max_steps = 0; io_guards = 0;
    reset = 0;
    tick(); tick();
    reset = 1;
    tick();
  endtask

  task automatic start_run(input logic mode, input int max, input int guards);
    io_mode = mode; io_max_steps = 16'(max); io_guards = N'(guards); io_start = 1;
    tick();
    io_start = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (io_en_a !== '0 || io_busy !== 0 || io_done !== 0 || io_deadlock !== 0 || io_step_count !== 0) begin
      failures++;
      $display("FAIL reset_state: en=%b busy=%b done=%b dl=%b cnt=%0d, required all zero",
               io_en_a, io_busy, io_done, io_deadlock, io_step_count);
    end
  endtask

  task automatic test_rr_fairness();
    logic [N-1:0] exp;
    start_run(0, 8, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = N'(1) << (k % N);
      checks++;
      if (io_en_a !== exp || io_busy !== 1) begin
        failures++;
        $display("FAIL rr_grant_%0d: en=%b busy=%b, required en=%b busy=1", k, io_en_a, io_busy, exp);
      end
      tick();
    end
    checks++;
    if (io_done !== 1 || io_step_count !== 16'd8 || io_en_a !== '0 || io_busy !== 0) begin
      failures++;
      $display("FAIL rr_done: done=%b cnt=%0d en=%b busy=%b, required done=1 cnt=8 en=0 busy=0",
               io_done, io_step_count, io_en_a, io_busy);
    end
  endtask

  task automatic test_sparse_wrap();
    logic [N-1:0] exp [3];
    exp[0] = 4'b0010; exp[1] = 4'b1000; exp[2] = 4'b0010;
    start_run(0, 3, 4'b1010);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (io_en_a !== exp[k]) begin
        failures++;
        $display("FAIL sparse_grant_%0d: en=%b, required %b", k, io_en_a, exp[k]);
      end
      tick();
    end
    checks++;
    if (io_done !== 1 || io_step_count !== 16'd3) begin
      failures++;
      $display("FAIL sparse_done: done=%b cnt=%0d, required done=1 cnt=3", io_done, io_step_count);
    end
  endtask

  task automatic test_deadlock();
    int early;
    early = 0;
    start_run(0, 0, 0);
    for (int k = 0; k < LIMIT - 1; k++) begin
      tick();
      if (io_deadlock !== 0 || io_en_a !== '0) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL deadlock_early: %0d premature cycles, required 0", early);
    end
    tick();
    checks++;
    if (io_deadlock !== 1 || io_en_a !== '0 || io_busy !== 0) begin
      failures++;
      $display("FAIL deadlock_flag: dl=%b en=%b busy=%b, required dl=1 en=0 busy=0",
               io_deadlock, io_en_a, io_busy);
    end
    start_run(0, 0, 0);
    checks++;
    if (io_deadlock !== 0 || io_busy !== 1) begin
      failures++;
      $display("FAIL deadlock_clear: dl=%b busy=%b, required dl=0 busy=1", io_deadlock, io_busy);
    end
  endtask

  // Continues from the freshly restarted SELECT left by test_deadlock
  task automatic test_hold();
    int bad;
    bad = 0;
    io_hold = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (io_deadlock !== 0 || io_step_count !== 0 || io_busy !== 1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_freeze: %0d bad cycles, required 0", bad);
    end
    io_hold = 0;
    for (int k = 0; k < LIMIT - 1; k++) tick();
    checks++;
    if (io_deadlock !== 0) begin
      failures++;
      $display("FAIL hold_release_early: dl=%b, required 0", io_deadlock);
    end
    tick();
    checks++;
    if (io_deadlock !== 1) begin
      failures++;
      $display("FAIL hold_release_dl: dl=%b, required 1", io_deadlock);
    end
  endtask

  task automatic test_lfsr();
    int l;
    logic [N-1:0] exp;
    l = 8'hA5;
    start_run(1, 4, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      exp = N'(1) << pick_rule(l % N, 15);
      l = lfsr_step(l);
      tick();
      checks++;
      if (io_en_a !== exp || (k == 0 && io_en_a !== 4'b0010)) begin
        failures++;
        $display("FAIL lfsr_grant_%0d: en=%b, required %b", k, io_en_a, exp);
      end
      tick();
    end
    checks++;
    if (io_done !== 1 || io_step_count !== 16'd4) begin
      failures++;
      $display("FAIL lfsr_done: done=%b cnt=%0d, required done=1 cnt=4", io_done, io_step_count);
    end
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    start_run(0, 0, 4'b1111);
    while (io_en_a !== 4'b0100 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (io_en_a !== 4'b0100) begin
      failures++;
      $display("FAIL async_reach_fire: en=%b, required 0100 within 20 cycles", io_en_a);
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if (io_en_a !== '0 || io_step_count !== 0 || io_busy !== 0 || io_done !== 0 || io_deadlock !== 0) begin
      failures++;
      $display("FAIL async_reset: en=%b cnt=%0d busy=%b done=%b dl=%b, required all zero",
               io_en_a, io_step_count, io_busy, io_done, io_deadlock);
    end
    tick();
    reset = 1;
    tick();
  endtask

  // Randomized run against a behavioural model of the scheduler's rules
  task automatic test_random();
    bit running, firing, fin, dead;
    int cnt, ptr, lfsr, idle, grant, max, pick, st;
    bit mode;
    int bad_en, bad_cnt, bad_flags;
    logic [N-1:0] exp_en;
    bit s_start, s_mode, s_hold;
    int s_max, s_guards;
    running = 0; firing = 0; fin = 0; dead = 0;
    cnt = 0; ptr = 0; lfsr = 8'hA5; idle = 0; grant = 0; max = 0; mode = 0;
    bad_en = 0; bad_cnt = 0; bad_flags = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      s_start  = ($urandom_range(0, 3) == 0);
      s_mode   = 1'($urandom_range(0, 1));
      s_hold   = ($urandom_range(0, 4) == 0);
      s_max    = $urandom_range(0, 6);
      s_guards = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
      if (c > 400 && c < 430) s_guards = 0;
      io_start = s_start; io_mode = s_mode; io_hold = s_hold;
      io_max_steps = 16'(s_max); io_guards = N'(s_guards);
      tick();
      if (firing) begin
        firing = 0;
        if (cnt < 65535) cnt++;
        ptr = (grant + 1) % N;
        if (max != 0 && cnt == max) fin = 1; else running = 1;
      end else if (running) begin
        if (!s_hold) begin
          st   = mode ? (lfsr % N) : ptr;
          lfsr = lfsr_step(lfsr);
          pick = pick_rule(st, s_guards);
          if (pick >= 0) begin
            grant = pick; firing = 1; running = 0; idle = 0;
          end else begin
            idle++;
            if (idle == LIMIT) begin dead = 1; running = 0; end
          end
        end
      end else if (s_start) begin
        cnt = 0; idle = 0; ptr = 0; lfsr = 8'hA5; mode = s_mode; max = s_max;
        fin = 0; dead = 0; running = 1;
      end
      exp_en = firing ? (N'(1) << grant) : '0;
      if (io_en_a !== exp_en) begin
        bad_en++;
        if (bad_en <= 3) $display("FAIL rand_en cycle %0d: en=%b, required %b", c, io_en_a, exp_en);
      end
      if (io_step_count !== 16'(cnt)) begin
        bad_cnt++;
        if (bad_cnt <= 3) $display("FAIL rand_cnt cycle %0d: cnt=%0d, required %0d", c, io_step_count, cnt);
      end
      if (io_busy !== (running | firing) || io_done !== fin || io_deadlock !== dead) begin
        bad_flags++;
        if (bad_flags <= 3)
          $display("FAIL rand_flags cycle %0d: busy=%b done=%b dl=%b, required %b %b %b",
                   c, io_busy, io_done, io_deadlock, running | firing, fin, dead);
      end
    end
    checks += 3;
    if (bad_en != 0)    failures++;
    if (bad_cnt != 0)   failures++;
    if (bad_flags != 0) failures++;
    io_start = 0; io_hold = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 0;
    test_reset();
    test_rr_fairness();
    test_sparse_wrap();
    test_deadlock();
    test_hold();
    test_lfsr();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/murphi_rule_scheduler.md
Name: murphi_rule_scheduler

Overview:
- Sequences the rule-enable vector of a Murphi-generated `system` block (the mutual-exclusion model with one-hot `io_en_a`).
- Each step samples the rule guards, picks exactly one enabled rule by round-robin or LFSR selection, and pulses its enable for one cycle.
- Counts fired steps, stops at a programmable step limit, and flags deadlock when no guard is true for too long.
- Drives the equivalence/simulation harness in place of free primary inputs.

Parameters:
- NUM_RULES, 4, number of rules; power of two, 2..16.
- DEADLOCK_LIMIT, 8, consecutive empty SELECT cycles before deadlock is declared; 1..255.
- LFSR_SEED, 8'hA5, LFSR load value; must be nonzero.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_start  input  1  start a run; honoured only in IDLE, DONE or DEADLOCK.
- io_mode  input  1  0 = round-robin, 1 = LFSR; sampled on io_start only.
- io_hold  input  1  pauses selection while high.
- io_max_steps  input  16  step limit; 0 = unlimited; sampled on io_start.
- io_guards  input  NUM_RULES  per-rule guard truth from the system.
- io_en_a  output  NUM_RULES  one-hot rule enable, registered; all-zero when no rule fires.
- io_busy  output  1  high in SELECT or FIRE.
- io_done  output  1  high in DONE.
- io_deadlock  output  1  high in DEADLOCK.
- io_step_count  output  16  rules fired since the last start.

Behaviour:
- Reset, while asserted (reset=0):
  - state=IDLE; io_en_a=0; io_step_count=0; RR pointer=0; LFSR=LFSR_SEED; idle counter=0.
  - All flags are 0.
- States: IDLE, SELECT, FIRE, DONE, DEADLOCK. Every registered output depends on state/regs only.
- IDLE/DONE/DEADLOCK with io_start=1:
  - Clear step count and idle counter; pointer=0; LFSR=LFSR_SEED.
  - Latch mode and max_steps; go to SELECT.
  - io_start in SELECT or FIRE is ignored.
- SELECT, io_hold=1:
  - Stay in SELECT; nothing changes (LFSR and idle counter frozen).
- SELECT, io_hold=0, guards≠0:
  - start = pointer (RR) or LFSR[log2(NUM_RULES)-1:0] (LFSR mode).
  - Grant = first set guard scanning start, start+1, … modulo NUM_RULES.
  - Register the grant one-hot into io_en_a; clear the idle counter; go to FIRE.
- SELECT, io_hold=0, guards=0:
  - io_en_a stays 0; idle counter +1.
  - If the new count equals DEADLOCK_LIMIT, go to DEADLOCK; otherwise stay in SELECT.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  - Advances once per non-held SELECT cycle, regardless of mode.
- FIRE:
  - io_en_a holds the grant for exactly this one cycle; io_hold is ignored.
  - Next edge: io_en_a=0; step_count+1 (saturates at 16'hFFFF); pointer = granted index+1 mod NUM_RULES.
  - If max_steps≠0 and the new count == max_steps, go to DONE; otherwise go to SELECT.
- Step timing: each fired rule takes exactly 2 cycles. Guards are sampled only in SELECT, so the system state is stable when guards are evaluated.
- DONE and DEADLOCK hold io_en_a=0 and keep step_count until the next io_start or reset.
- Reset asserted mid-FIRE: io_en_a drops to 0 immediately (asynchronously); no step is counted.
- Invariant: popcount(io_en_a) ≤ 1, and io_en_a≠0 only in FIRE.

Test Plan:
- Round-robin fairness:
  - Stimulus: reset, start with mode=0, max_steps=8, guards=4'b1111.
  - Required: io_en_a sequence 0001,0010,0100,1000,0001,0010,0100,1000 on alternate cycles; io_done after the 8th step; step_count=8.
- Sparse guards, RR skip/wrap:
  - Stimulus: mode=0, guards=4'b1010, max_steps=3.
  - Required: grants 0010,1000,0010; pointer wraps 3→0→1.
- Deadlock:
  - Stimulus: guards=0 after start, DEADLOCK_LIMIT=8.
  - Required: io_deadlock=1 exactly 8 SELECT cycles after start; io_en_a stays 0; a new io_start clears it.
- Hold:
  - Stimulus: assert io_hold for 20 cycles in SELECT with guards=0.
  - Required: no deadlock, and step_count unchanged; on release, deadlock occurs after 8 more cycles.
- LFSR mode:
  - Stimulus: mode=1, seed A5, guards=4'b1111, max_steps=4.
  - Required: first grant index = A5[1:0]=1 → 0010; later grants match the reference LFSR model; exactly one-hot each FIRE.
- Async reset mid-FIRE:
  - Stimulus: drop reset while io_en_a=0100.
  - Required: io_en_a=0, step_count=0 and state=IDLE, all without waiting for a clock edge.
